nios_system_onchip_memory_dp: RTL and testbench

Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1 for the Nios II data master, s2 for a DMA/video master). It generalises the single-port on-chip memory with configurable width and depth, selectable read latency, a readdatavalid pipeline, clock-enable stalls, a defined same-cycle collision policy and an optional post-reset clear sweep. It sits in nios_system between the interconnect and the inferred block RAM.

---
 rtl/nios_system_onchip_memory_dp.sv | 158 +++++++++++++++
 tb/tb_nios_system_onchip_memory_dp.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves (s1: CPU data, s2: DMA/video) and an optional post-reset clear.
// Latency: a read accepted at edge N shows readdata/readdatavalid after edge N+READ_LATENCY; each clken-low edge adds one.
// Backpressure: waitrequest = busy | ~clken; no other stalls, so each port accepts one command per enabled cycle.
//
// Ports:
//   clk, reset (sync, active-high), clken (global enable, low freezes everything)
//   sN_address/byteenable/read/write/writedata  : Avalon-MM command inputs, N = 1, 2
//   sN_readdata/readdatavalid/waitrequest       : Avalon-MM responses
//   busy                                        : clear sweep in progress
module nios_system_onchip_memory_dp #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 16384,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic [DATA_W/8-1:0]   s2_byteenable,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [DATA_W-1:0]     s2_writedata,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_waitrequest,
  output logic                  busy
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic s1_wr_acc, s1_rd_acc, s2_wr_acc, s2_rd_acc;

  // While reset is held the outputs must already reflect the post-reset
  // state, so busy is forced from the parameter rather than the register.
  assign busy           = reset ? CLEAR_ON_RESET : (state_q == CLEAR);
  assign s1_waitrequest = busy | ~clken;
  assign s2_waitrequest = busy | ~clken;

  // Write wins over read on the same port; the read is simply dropped.
  assign s1_wr_acc = s1_write & ~s1_waitrequest & ~reset;
  assign s1_rd_acc = s1_read & ~s1_write & ~s1_waitrequest & ~reset;
  assign s2_wr_acc = s2_write & ~s2_waitrequest & ~reset;
  assign s2_rd_acc = s2_read & ~s2_write & ~s2_waitrequest & ~reset;

  // Clear FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr_we) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    if (state_q == CLEAR && clken && !reset) begin
      clr_we = 1'b1;
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
    end
  end

  // Array write. The clear sweep and command writes never overlap because
  // waitrequest is high throughout CLEAR. s2 lanes are written first so a
  // later s1 write to the same lane overrides it: s1 wins collisions lane by
  // lane, lanes enabled only by s2 keep s2 data.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_cnt_q] <= '0;
    for (int b = 0; b < NB; b++) begin
      if (s2_wr_acc && s2_byteenable[b])
        mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
    end
    for (int b = 0; b < NB; b++) begin
      if (s1_wr_acc && s1_byteenable[b])
        mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
    end
  end

  // Read capture at the accepting edge (old-data for same-edge writes),
  // followed by an output register. Data registers load only on a valid
  // beat so readdata holds its last value between beats.
  logic              s1_v0_q, s2_v0_q, s1_v1_q, s2_v1_q;
  logic [DATA_W-1:0] s1_d0_q, s2_d0_q, s1_d1_q, s2_d1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v0_q <= 1'b0;
      s2_v0_q <= 1'b0;
      s1_v1_q <= 1'b0;
      s2_v1_q <= 1'b0;
      s1_d0_q <= '0;
      s2_d0_q <= '0;
      s1_d1_q <= '0;
      s2_d1_q <= '0;
    end else if (clken) begin
      s1_v0_q <= s1_rd_acc;
      s2_v0_q <= s2_rd_acc;
      if (s1_rd_acc) s1_d0_q <= mem[s1_address];
      if (s2_rd_acc) s2_d0_q <= mem[s2_address];
      s1_v1_q <= s1_v0_q;
      s2_v1_q <= s2_v0_q;
      if (s1_v0_q) s1_d1_q <= s1_d0_q;
      if (s2_v0_q) s2_d1_q <= s2_d0_q;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              s1_v2_q, s2_v2_q;
      logic [DATA_W-1:0] s1_d2_q, s2_d2_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          s1_v2_q <= 1'b0;
          s2_v2_q <= 1'b0;
          s1_d2_q <= '0;
          s2_d2_q <= '0;
        end else if (clken) begin
          s1_v2_q <= s1_v1_q;
          s2_v2_q <= s2_v1_q;
          if (s1_v1_q) s1_d2_q <= s1_d1_q;
          if (s2_v1_q) s2_d2_q <= s2_d1_q;
        end
      end

      assign s1_readdata      = s1_d2_q;
      assign s1_readdatavalid = s1_v2_q;
      assign s2_readdata      = s2_d2_q;
      assign s2_readdatavalid = s2_v2_q;
    end else begin : g_lat1
      assign s1_readdata      = s1_d1_q;
      assign s1_readdatavalid = s1_v1_q;
      assign s2_readdata      = s2_d1_q;
      assign s2_readdatavalid = s2_v1_q;
    end
  endgenerate

endmodule

// File: tb/tb_nios_system_onchip_memory_dp.sv
`timescale 1ns/1ps
module tb_nios_system_onchip_memory_dp;

  localparam int DW  = 32;
  localparam int AW  = 4;

  logic clk = 1'b0;
  int   cyc = 0;

  // index [d]: 0 = latency-1 instance, 1 = latency-2 clear-on-reset instance
  // index [p]: 0 = s1, 1 = s2
  logic          rst  [2];
  logic          ce   [2];
  logic          busy [2];
  logic          en_last [2];
  logic [AW-1:0] addr [2][2];
  logic [3:0]    be   [2][2];
  logic          rd   [2][2];
  logic          wr   [2][2];
  logic [DW-1:0] wdat [2][2];
  logic [DW-1:0] rdat [2][2];
  logic          rvld [2][2];
  logic          wreq [2][2];

  typedef struct {
    int          d;
    int          p;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  nios_system_onchip_memory_dp #(
    .DATA_W(32), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
  ) dut_a (
    .clk(clk), .reset(rst[0]), .clken(ce[0]),
    .s1_address(addr[0][0]), .s1_byteenable(be[0][0]), .s1_read(rd[0][0]),
    .s1_write(wr[0][0]), .s1_writedata(wdat[0][0]), .s1_readdata(rdat[0][0]),
    .s1_readdatavalid(rvld[0][0]), .s1_waitrequest(wreq[0][0]),
    .s2_address(addr[0][1]), .s2_byteenable(be[0][1]), .s2_read(rd[0][1]),
    .s2_write(wr[0][1]), .s2_writedata(wdat[0][1]), .s2_readdata(rdat[0][1]),
    .s2_readdatavalid(rvld[0][1]), .s2_waitrequest(wreq[0][1]),
    .busy(busy[0])
  );

  nios_system_onchip_memory_dp #(
    .DATA_W(32), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst[1]), .clken(ce[1]),
    .s1_address(addr[1][0]), .s1_byteenable(be[1][0]), .s1_read(rd[1][0]),
    .s1_write(wr[1][0]), .s1_writedata(wdat[1][0]), .s1_readdata(rdat[1][0]),
    .s1_readdatavalid(rvld[1][0]), .s1_waitrequest(wreq[1][0]),
    .s2_address(addr[1][1]), .s2_byteenable(be[1][1]), .s2_read(rd[1][1]),
    .s2_write(wr[1][1]), .s2_writedata(wdat[1][1]), .s2_readdata(rdat[1][1]),
    .s2_readdatavalid(rvld[1][1]), .s2_waitrequest(wreq[1][1]),
    .busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) en_last[d] <= ce[d];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a beat is a valid output produced by an enabled edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (rvld[d][p] === 1'b1 && en_last[d] === 1'b1) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].d == d && sb[i].p == p) begin
              idx = i;
              break;
            end
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat dut%0d s%0d: got data %h at cycle %0d, required no beat",
                     d, p + 1, rdat[d][p], cyc);
          end else begin
            check($sformatf("beat_data dut%0d s%0d", d, p + 1), rdat[d][p], sb[idx].data);
            check($sformatf("beat_cycle dut%0d s%0d", d, p + 1), cyc, sb[idx].cyc);
            sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        rd[d][p] = 1'b0;
        wr[d][p] = 1'b0;
      end
  endtask

  task automatic wr_cmd(int d, int p, logic [AW-1:0] a, logic [31:0] v, logic [3:0] b);
    addr[d][p] = a;
    wdat[d][p] = v;
    be[d][p]   = b;
    wr[d][p]   = 1'b1;
    rd[d][p]   = 1'b0;
  endtask

  // Issue a read to be accepted at the next edge; stall = number of
  // clken-low edges the bench will insert while it is in flight.
  task automatic rd_cmd(int d, int p, logic [AW-1:0] a, logic [31:0] e, int stall);
    int lat;
    lat = (d == 0) ? 1 : 2;
    addr[d][p] = a;
    rd[d][p]   = 1'b1;
    wr[d][p]   = 1'b0;
    sb.push_back('{d: d, p: p, data: e, cyc: cyc + 1 + lat + stall});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      ce[d]  = 1'b1;
      en_last[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        addr[d][p] = '0;
        be[d][p]   = '0;
        wdat[d][p] = '0;
      end
    end
    idle();
    tick();
    tick();

    // Reset values
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rst_vld dut%0d s%0d", d, p + 1), 32'(rvld[d][p]), 32'd0);
        check($sformatf("rst_rdata dut%0d s%0d", d, p + 1), rdat[d][p], 32'd0);
      end
    check("rst_busy_a", 32'(busy[0]), 32'd0);
    check("rst_busy_b", 32'(busy[1]), 32'd1);
    check("rst_wait_a", 32'(wreq[0][0]), 32'd0);
    check("rst_wait_b_s1", 32'(wreq[1][0]), 32'd1);
    check("rst_wait_b_s2", 32'(wreq[1][1]), 32'd1);
    ce[0] = 1'b0;
    #1;
    check("rst_wait_a_clken_low", 32'(wreq[0][1]), 32'd1);
    ce[0] = 1'b1;
    rst[0] = 1'b0;

    // ---- instance A: latency 1 ----
    wr_cmd(0, 0, 4'd5, 32'hDEADBEEF, 4'hF); tick();
    idle(); rd_cmd(0, 0, 4'd5, 32'hDEADBEEF, 0); tick(); idle();

    wr_cmd(0, 0, 4'd7, 32'h11223344, 4'hF); tick();
    wr_cmd(0, 0, 4'd7, 32'hAABBCCDD, 4'b0101); tick();
    rd_cmd(0, 0, 4'd7, 32'h11BB33DD, 0);
    rd_cmd(0, 1, 4'd7, 32'h11BB33DD, 0); tick(); idle();

    // Old-data read on s2 while s1 writes
    wr_cmd(0, 0, 4'd9, 32'h0, 4'hF); tick();
    wr_cmd(0, 0, 4'd9, 32'h000000FF, 4'b0001);
    rd_cmd(0, 1, 4'd9, 32'h0, 0); tick(); idle();

    // Same-address collision
    wr_cmd(0, 0, 4'd9, 32'h0, 4'hF); tick();
    wr_cmd(0, 0, 4'd9, 32'h000000FF, 4'b0001);
    wr_cmd(0, 1, 4'd9, 32'h0000AA00, 4'b0011); tick(); idle();
    rd_cmd(0, 0, 4'd9, 32'h0000AAFF, 0); tick(); idle();

    // s1 read during s2 write, then s2 read-after-write next cycle
    wr_cmd(0, 1, 4'd9, 32'h12345678, 4'hF);
    rd_cmd(0, 0, 4'd9, 32'h0000AAFF, 0); tick(); idle();
    rd_cmd(0, 1, 4'd9, 32'h12345678, 0); tick(); idle();

    // Back-to-back reads on both ports
    rd_cmd(0, 0, 4'd5, 32'hDEADBEEF, 0);
    rd_cmd(0, 1, 4'd7, 32'h11BB33DD, 0); tick();
    rd_cmd(0, 0, 4'd7, 32'h11BB33DD, 0);
    rd_cmd(0, 1, 4'd5, 32'hDEADBEEF, 0); tick(); idle();
    rd_cmd(0, 0, 4'd9, 32'h12345678, 0); tick(); idle();

    // Read and write together: write kept, read dropped
    addr[0][0] = 4'd4; wdat[0][0] = 32'h00000055; be[0][0] = 4'hF;
    wr[0][0] = 1'b1; rd[0][0] = 1'b1; tick(); idle();
    rd_cmd(0, 0, 4'd4, 32'h00000055, 0); tick(); idle();

    // One clken-low edge while a read is in flight
    rd_cmd(0, 0, 4'd7, 32'h11BB33DD, 1); tick(); idle();
    ce[0] = 1'b0; #1;
    check("stall_wait_a", 32'(wreq[0][0]), 32'd1);
    tick(); ce[0] = 1'b1; tick(); tick();

    // Reset one cycle after a read is accepted: flushed, readdata cleared
    addr[0][0] = 4'd5; rd[0][0] = 1'b1; tick(); idle();
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    check("flush_vld", 32'(rvld[0][0]), 32'd0);
    check("flush_rdata", rdat[0][0], 32'd0);
    tick(); tick();
    check("flush_rdata_later", rdat[0][0], 32'd0);
    rd_cmd(0, 0, 4'd5, 32'hDEADBEEF, 0); tick(); idle(); tick(); tick();

    // ---- instance B: latency 2, clear on reset ----
    rst[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("clear_busy_%0d", i), 32'(busy[1]), 32'd1);
      check($sformatf("clear_wait_%0d", i), 32'(wreq[1][0]), 32'd1);
      tick();
    end
    check("clear_done_busy", 32'(busy[1]), 32'd0);
    check("clear_done_wait", 32'(wreq[1][1]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_cmd(1, i % 2, AW'(i), 32'h0, 0); tick(); idle();
    end

    // Read-latency-2 stream with one clken-low edge after the 2nd accept
    for (int i = 0; i < 4; i++) begin
      wr_cmd(1, 0, AW'(i), 32'hA0 + i, 4'hF); tick();
    end
    idle();
    rd_cmd(1, 0, 4'd0, 32'hA0, 1); tick();
    rd_cmd(1, 0, 4'd1, 32'hA1, 1); tick();
    ce[1] = 1'b0; addr[1][0] = 4'd2; rd[1][0] = 1'b1; #1;
    check("stall_wait_b", 32'(wreq[1][0]), 32'd1);
    tick(); ce[1] = 1'b1;
    rd_cmd(1, 0, 4'd2, 32'hA2, 0); tick();
    rd_cmd(1, 0, 4'd3, 32'hA3, 0); tick(); idle();
    for (int i = 0; i < 4; i++) tick();

    // Preload nonzero data, then pulse reset and expect a full clear
    for (int i = 0; i < 16; i++) begin
      wr_cmd(1, 1, AW'(i), 32'h100 + i, 4'hF); tick();
    end
    idle();
    rd_cmd(1, 0, 4'd3, 32'h103, 0); tick(); idle();
    for (int i = 0; i < 3; i++) tick();
    rst[1] = 1'b1; tick(); rst[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("reclear_busy_%0d", i), 32'(busy[1]), 32'd1);
      check($sformatf("reclear_wait_%0d", i), 32'(wreq[1][1]), 32'd1);
      tick();
    end
    check("reclear_done_busy", 32'(busy[1]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_cmd(1, (i + 1) % 2, AW'(i), 32'h0, 0); tick(); idle();
    end
    for (int i = 0; i < 6; i++) tick();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
